csr_spi_master: RTL and testbench

SPI initiator for the caster CSR port. It converts single-register read and write requests into 16-bit SPI frames on `spi_cs`/`spi_sck`/`spi_mosi`/`spi_miso`, the far end of the CSR slave inside caster. It is used as an on-chip boot configurator and as the bench-side driver for the CSR interface. Its SPI outputs drive the top-level SPI pins directly.

---
 rtl/csr_spi_master.sv | 276 +++++++++++++++++++++++++++
 tb/tb_csr_spi_master.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_spi_master.sv
// -----------------------------------------------------------------------------
// csr_spi_master
//
// SPI initiator for the caster CSR port. Turns single-register read/write
// requests into 16-bit mode-0 frames {rw, addr[6:0], data[7:0]}, MSB first.
// Every output is a flop; nothing on the SPI pins is combinational from an input.
//
// Parameters:
//   CLK_DIV  clk cycles per SCK half-period (>= 2)
//   CS_GAP   clk cycles of CS setup, CS hold and inter-frame gap (>= 1)
//
// Ports:
//   clk                      rising-edge clock
//   rst_n                    synchronous active-low reset
//   req_valid / req_ready    request handshake (accepted when both high)
//   req_write, req_addr,
//   req_wdata                request fields, captured at acceptance
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata                last 8 MISO bits of the frame, held until next rsp
//   rsp_err                  readback mismatch, qualified by rsp_valid
//   busy                     inverse of req_ready
//   spi_cs, spi_sck,
//   spi_mosi, spi_miso       SPI pins (CS active low, SCK idles low)
//
// Optional feature macro: CSR_SPI_VERIFY_EN
//   When defined, every write is followed by an automatic readback frame to the
//   same address; rsp_valid fires only after the readback and rsp_err flags a
//   mismatch against the written data. When undefined, one frame per request
//   and rsp_err is tied low.
// -----------------------------------------------------------------------------
module csr_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       spi_cs,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W = $clog2(CS_GAP) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [4:0]       BIT_LAST = 5'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [4:0]         bit_cnt_r;
    logic               sck_r;          // also the low/high phase flag while shifting
    logic [14:0]        shift_out_r;    // bits still to send after the one on MOSI
    logic [7:0]         shift_in_r;
    logic               mosi_r;
    logic               cs_r;
    logic               req_ready_r;
    logic               busy_r;
    logic               rsp_valid_r;
    logic [7:0]         rsp_rdata_r;
    logic               rsp_err_r;

    logic               gap_last_s;
    logic               div_last_s;
    logic               bit_last_s;
    logic               accept_s;
    logic               bit_end_s;
    logic               rsp_fire_s;
    logic               chain_start_s;
    logic               chain_rd_s;
    logic               err_s;
    logic [14:0]        rdbk_frame_s;

`ifdef CSR_SPI_VERIFY_EN
    logic               wr_r;
    logic               rdbk_r;
    logic [6:0]         addr_r;
    logic [7:0]         wdata_r;

    // Captures the request so a readback frame can follow a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_r    <= 1'b0;
            rdbk_r  <= 1'b0;
            addr_r  <= 7'd0;
            wdata_r <= 8'd0;
        end else if (accept_s) begin
            wr_r    <= req_write;
            rdbk_r  <= 1'b0;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end else if (chain_start_s) begin
            rdbk_r  <= 1'b1;
        end else begin
            rdbk_r  <= rdbk_r;
        end
    end

    // Readback control: chain after the write frame, compare on the readback.
    always_comb begin
        chain_rd_s   = wr_r && !rdbk_r;
        err_s        = rdbk_r && (shift_in_r != wdata_r);
        rdbk_frame_s = {addr_r, 8'h00};
    end
`else
    // Without readback every request is a single frame and never errors.
    always_comb begin
        chain_rd_s   = 1'b0;
        err_s        = 1'b0;
        rdbk_frame_s = 15'd0;
    end
`endif

    // Counter terminal counts and single-cycle event strobes.
    always_comb begin
        gap_last_s    = (gap_cnt_r == GAP_LAST);
        div_last_s    = (div_cnt_r == DIV_LAST);
        bit_last_s    = (bit_cnt_r == BIT_LAST);
        accept_s      = (state_r == ST_IDLE) && req_valid;
        bit_end_s     = (state_r == ST_SHIFT) && sck_r && div_last_s;
        rsp_fire_s    = (state_r == ST_HOLD) && gap_last_s && !chain_rd_s;
        chain_start_s = (state_r == ST_GAP) && gap_last_s && chain_rd_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) state_nxt_s = ST_SETUP;
                else           state_nxt_s = ST_IDLE;
            end
            ST_SETUP: begin
                if (gap_last_s) state_nxt_s = ST_SHIFT;
                else            state_nxt_s = ST_SETUP;
            end
            ST_SHIFT: begin
                if (bit_end_s && bit_last_s) state_nxt_s = ST_HOLD;
                else                         state_nxt_s = ST_SHIFT;
            end
            ST_HOLD: begin
                if (gap_last_s) state_nxt_s = ST_GAP;
                else            state_nxt_s = ST_HOLD;
            end
            ST_GAP: begin
                if (gap_last_s && chain_rd_s) state_nxt_s = ST_SETUP;
                else if (gap_last_s)          state_nxt_s = ST_IDLE;
                else                          state_nxt_s = ST_GAP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Phase counters: CS setup/hold/gap timer and the SCK divider/bit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt_r <= '0;
            div_cnt_r <= '0;
            bit_cnt_r <= 5'd0;
            sck_r     <= 1'b0;
        end else begin
            // Restart on every state change so the timer never wraps.
            if (state_nxt_s != state_r) begin
                gap_cnt_r <= '0;
            end else if ((state_r == ST_SETUP) || (state_r == ST_HOLD) || (state_r == ST_GAP)) begin
                gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end else begin
                gap_cnt_r <= '0;
            end

            if (state_r != ST_SHIFT) begin
                div_cnt_r <= '0;
                bit_cnt_r <= 5'd0;
                sck_r     <= 1'b0;
            end else if (div_last_s) begin
                div_cnt_r <= '0;
                sck_r     <= !sck_r;
                if (sck_r) bit_cnt_r <= bit_cnt_r + 5'd1;
                else       bit_cnt_r <= bit_cnt_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
        end
    end

    // Serial data: load the frame, advance MOSI at the start of each low phase,
    // sample MISO at the end of each high phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_r      <= 1'b0;
            shift_out_r <= 15'd0;
            shift_in_r  <= 8'd0;
        end else begin
            if (accept_s) begin
                mosi_r      <= req_write;
                shift_out_r <= {req_addr, (req_write ? req_wdata : 8'h00)};
            end else if (chain_start_s) begin
                mosi_r      <= 1'b0;
                shift_out_r <= rdbk_frame_s;
            end else if (bit_end_s && !bit_last_s) begin
                mosi_r      <= shift_out_r[14];
                shift_out_r <= {shift_out_r[13:0], 1'b0};
            end else if (rsp_fire_s) begin
                mosi_r      <= 1'b0;
            end else begin
                mosi_r      <= mosi_r;
            end

            if (bit_end_s) shift_in_r <= {shift_in_r[6:0], spi_miso};
            else           shift_in_r <= shift_in_r;
        end
    end

    // Registered status, chip select and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_r        <= 1'b1;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 8'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            cs_r        <= !((state_nxt_s == ST_SETUP) || (state_nxt_s == ST_SHIFT) ||
                             (state_nxt_s == ST_HOLD));
            req_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            rsp_valid_r <= rsp_fire_s;
            if (rsp_fire_s) begin
                rsp_rdata_r <= shift_in_r;
                rsp_err_r   <= err_s;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
                rsp_err_r   <= rsp_err_r;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign spi_cs    = cs_r;
    assign spi_sck   = sck_r;
    assign spi_mosi  = mosi_r;

endmodule

// File: tb/tb_csr_spi_master.sv
// -----------------------------------------------------------------------------
// tb_csr_spi_master
//
// Self-checking bench for csr_spi_master with default parameters. A behavioural
// SPI slave with a 128-byte register file answers frames; a reference memory
// and the frame/timing formulas give every expected value.
// -----------------------------------------------------------------------------
module tb_csr_spi_master;

    localparam int D        = 4;
    localparam int G        = 2;
    localparam int T_VALID  = 2 * G + 32 * D + 1;
    localparam int T_READY  = 3 * G + 32 * D + 1;
    localparam int FRAME_T  = 3 * G + 32 * D;
`ifdef CSR_SPI_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       spi_cs;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;

    csr_spi_master #(.CLK_DIV(D), .CS_GAP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .spi_cs    (spi_cs),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  slave_mem [128];
    logic [7:0]  model_mem [128];
    logic [7:0]  corrupt_mask;
    logic [15:0] frame_q [$];
    int          bits_q  [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural mode-0 slave: captures MOSI on SCK rise, drives MISO after SCK
    // fall, returns the addressed register in the data byte, stores writes.
    initial begin : slave
        logic        prev_cs;
        logic        prev_sck;
        logic [15:0] sh;
        int          nb;
        logic [7:0]  rbyte;
        prev_cs  = 1'b1;
        prev_sck = 1'b0;
        sh       = 16'h0;
        nb       = 0;
        rbyte    = 8'h0;
        spi_miso = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_cs && !spi_cs) begin
                nb = 0;
                sh = 16'h0;
                spi_miso = 1'b0;
            end else if (!spi_cs && !prev_sck && spi_sck) begin
                sh = {sh[14:0], spi_mosi};
                nb++;
                if (nb == 8) rbyte = slave_mem[sh[6:0]];
            end else if (!spi_cs && prev_sck && !spi_sck) begin
                if (nb >= 8 && nb < 16) spi_miso = rbyte[15 - nb];
                else                    spi_miso = 1'b0;
            end else if (!prev_cs && spi_cs) begin
                frame_q.push_back(sh);
                bits_q.push_back(nb);
                if (nb == 16 && sh[15]) slave_mem[sh[14:8]] = sh[7:0] ^ corrupt_mask;
                spi_miso = 1'b0;
            end
            prev_cs  = spi_cs;
            prev_sck = spi_sck;
        end
    end

    // One request, observed until req_ready returns. Times are relative to the
    // acceptance cycle.
    task automatic run_txn(input logic wr, input logic [6:0] a, input logic [7:0] wd,
                           output logic [7:0] rd, output logic er,
                           output int tv, output int tr, output int np);
        int c0;
        int t;
        bit got;
        rd = 8'h0; er = 1'b0; tv = -1; tr = -1; np = 0; got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) begin
            chk("ready_wait", 32'(req_ready), 32'd1);
            return;
        end
        req_write = wr; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        c0 = cyc;
        @(negedge clk);
        // Fields change after capture; the DUT must ignore them.
        req_valid = 1'b0; req_write = ~wr;
        req_addr  = 7'($urandom); req_wdata = 8'($urandom);
        t = cyc - c0;
        while (!req_ready && t < 2000) begin
            if (rsp_valid) begin
                np++; tv = t; rd = rsp_rdata; er = rsp_err;
            end
            @(negedge clk);
            t = cyc - c0;
        end
        if (rsp_valid) np++;
        tr = t;
    endtask

    task automatic check_txn(input string tag, input logic wr, input logic [6:0] a,
                             input logic [7:0] wd, input logic [15:0] exp_frame,
                             input logic [7:0] exp_rd, input logic exp_err);
        logic [7:0]  rd;
        logic        er;
        int          tv, tr, np, nfr, nb;
        logic [15:0] w;
        nfr = (VERIFY && wr) ? 2 : 1;
        run_txn(wr, a, wd, rd, er, tv, tr, np);
        chk({tag, " pulses"},  32'(np), 32'd1);
        chk({tag, " t_valid"}, 32'(tv), 32'((nfr - 1) * FRAME_T + T_VALID));
        chk({tag, " t_ready"}, 32'(tr), 32'((nfr - 1) * FRAME_T + T_READY));
        chk({tag, " rdata"},   32'(rd), 32'(exp_rd));
        chk({tag, " err"},     32'(er), 32'(exp_err));
        chk({tag, " frames"},  32'(frame_q.size()), 32'(nfr));
        for (int f = 0; f < nfr && frame_q.size() > 0; f++) begin
            w  = frame_q.pop_front();
            nb = bits_q.pop_front();
            chk({tag, " bits"}, 32'(nb), 32'd16);
            chk({tag, " mosi"}, 32'(w), 32'((f == 0) ? exp_frame : {1'b0, a, 8'h00}));
        end
        frame_q.delete();
        bits_q.delete();
    endtask

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [7:0]  wd;
        logic [15:0] frame;
        logic [7:0]  rd_plain;   // expected rdata without readback verify
    } vec_t;

    vec_t vecs [7];

    initial begin : main
        logic [7:0] exp_rd;
        vecs[0] = '{1'b1, 7'h12, 8'hA5, 16'h92A5, 8'h52};
        vecs[1] = '{1'b0, 7'h05, 8'h00, 16'h0500, 8'h3C};
        vecs[2] = '{1'b0, 7'h12, 8'h00, 16'h1200, 8'hA5};
        vecs[3] = '{1'b1, 7'h7F, 8'hFF, 16'hFFFF, 8'hBF};
        vecs[4] = '{1'b1, 7'h00, 8'h00, 16'h8000, 8'h40};
        vecs[5] = '{1'b0, 7'h7F, 8'h00, 16'h7F00, 8'hFF};
        vecs[6] = '{1'b0, 7'h00, 8'h00, 16'h0000, 8'h00};

        for (int i = 0; i < 128; i++) begin
            slave_mem[i] = 8'(i) + 8'h40;
            model_mem[i] = 8'(i) + 8'h40;
        end
        slave_mem[5] = 8'h3C;
        model_mem[5] = 8'h3C;
        corrupt_mask = 8'h00;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 7'h0; req_wdata = 8'h0;
        repeat (3) @(negedge clk);
        chk("reset spi_cs",    32'(spi_cs),    32'd1);
        chk("reset spi_sck",   32'(spi_sck),   32'd0);
        chk("reset spi_mosi",  32'(spi_mosi),  32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset rsp_err",   32'(rsp_err),   32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset busy",      32'(busy),      32'd0);
        rst_n = 1'b1;

        begin : idle
            int pulses, cs_low, sck_hi;
            pulses = 0; cs_low = 0; sck_hi = 0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (rsp_valid) pulses++;
                if (!spi_cs)   cs_low++;
                if (spi_sck)   sck_hi++;
            end
            chk("idle rsp_valid", 32'(pulses), 32'd0);
            chk("idle spi_cs",    32'(cs_low), 32'd0);
            chk("idle spi_sck",   32'(sck_hi), 32'd0);
            chk("idle req_ready", 32'(req_ready), 32'd1);
        end

        for (int i = 0; i < 7; i++) begin
            exp_rd = (VERIFY && vecs[i].wr) ? vecs[i].wd : vecs[i].rd_plain;
            check_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wd,
                      vecs[i].frame, exp_rd, 1'b0);
            if (vecs[i].wr) model_mem[vecs[i].addr] = vecs[i].wd;
        end

        // Back-to-back: req_valid held high, junk fields presented while busy.
        begin : b2b
            logic [6:0] ba [3];
            int         acc [3];
            int         idx, hi_run, pulses;
            bit         seen_low;
            int         runs [$];
            logic [7:0] rds [$];
            logic [15:0] w;
            ba = '{7'h05, 7'h12, 7'h7F};
            idx = 0; hi_run = 0; pulses = 0; seen_low = 1'b0;
            acc = '{0, 0, 0};
            for (int n = 0; n < 2000; n++) begin
                @(negedge clk);
                if (spi_cs) begin
                    hi_run++;
                end else begin
                    if (seen_low && hi_run > 0) runs.push_back(hi_run);
                    hi_run = 0;
                    seen_low = 1'b1;
                end
                if (rsp_valid) begin
                    pulses++;
                    rds.push_back(rsp_rdata);
                end
                if (idx == 3 && pulses == 3 && req_ready) break;
                if (req_ready && idx < 3) begin
                    req_write = 1'b0; req_addr = ba[idx]; req_wdata = 8'hEE;
                    req_valid = 1'b1; acc[idx] = cyc; idx++;
                end else if (idx < 3) begin
                    req_write = 1'b1; req_addr = 7'($urandom); req_wdata = 8'($urandom);
                    req_valid = 1'b1;
                end else begin
                    req_valid = 1'b0;
                end
            end
            req_valid = 1'b0;
            chk("b2b accepted", 32'(idx),    32'd3);
            chk("b2b pulses",   32'(pulses), 32'd3);
            chk("b2b period01", 32'(acc[1] - acc[0]), 32'(T_READY));
            chk("b2b period12", 32'(acc[2] - acc[1]), 32'(T_READY));
            // Inter-frame CS-high run: G gap cycles plus the idle/accept cycle.
            chk("b2b gap runs", 32'(runs.size()), 32'd2);
            for (int i = 0; i < runs.size(); i++) chk("b2b gap len", 32'(runs[i]), 32'(G + 1));
            chk("b2b frames", 32'(frame_q.size()), 32'd3);
            for (int i = 0; i < 3 && frame_q.size() > 0; i++) begin
                w = frame_q.pop_front();
                chk("b2b mosi", 32'(w), 32'({1'b0, ba[i], 8'h00}));
            end
            for (int i = 0; i < 3 && i < rds.size(); i++)
                chk("b2b rdata", 32'(rds[i]), 32'(model_mem[ba[i]]));
            frame_q.delete();
            bits_q.delete();
        end

        // Reset in the middle of a write frame drops it silently.
        begin : midrst
            int c0, pulses;
            bit got;
            got = 1'b0;
            for (int i = 0; i < 1000 && !got; i++) begin
                @(negedge clk);
                got = req_ready;
            end
            req_write = 1'b1; req_addr = 7'h33; req_wdata = 8'h77; req_valid = 1'b1;
            c0 = cyc;
            @(negedge clk);
            req_valid = 1'b0;
            while (cyc - c0 < G + 1 + 15 * D) @(negedge clk);
            chk("midrst in bit7 high", 32'(spi_sck), 32'd1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            chk("midrst spi_cs",    32'(spi_cs),    32'd1);
            chk("midrst spi_sck",   32'(spi_sck),   32'd0);
            chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
            chk("midrst req_ready", 32'(req_ready), 32'd1);
            chk("midrst busy",      32'(busy),      32'd0);
            pulses = 0;
            for (int n = 0; n < 300; n++) begin
                @(negedge clk);
                if (rsp_valid) pulses++;
            end
            chk("midrst no rsp", 32'(pulses), 32'd0);
            frame_q.delete();
            bits_q.delete();
            check_txn("after_rst", 1'b0, 7'h33, 8'h00, 16'h3300, model_mem[7'h33], 1'b0);
        end

`ifdef CSR_SPI_VERIFY_EN
        corrupt_mask = 8'h01;
        check_txn("verify_corrupt", 1'b1, 7'h21, 8'h55, 16'hA155, 8'h54, 1'b1);
        corrupt_mask = 8'h00;
        model_mem[7'h21] = 8'h54;
`endif

        // Randomised traffic against the reference memory.
        for (int i = 0; i < 25; i++) begin
            logic       wr;
            logic [6:0] a;
            logic [7:0] wd;
            wr = 1'($urandom_range(0, 1));
            a  = 7'($urandom);
            wd = 8'($urandom);
            exp_rd = (VERIFY && wr) ? wd : model_mem[a];
            check_txn($sformatf("rand%0d", i), wr, a, wd,
                      {wr, a, (wr ? wd : 8'h00)}, exp_rd, 1'b0);
            if (wr) model_mem[a] = wd;
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
